// File: rtl/mc_ctrl_fsm_if.sv
// Shared instruction/data memory handshake between the control sequencer
// (master) and the memory port (slave).
interface mc_ctrl_fsm_if;
  logic mem_req;    // memory request
  logic mem_we;     // store write strobe
  logic mem_sel;    // 0 = PC address, 1 = ALU-result address
  logic mem_ready;  // memory accepts/returns data this cycle

  modport master (
    output mem_req,
    output mem_we,
    output mem_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_sel,
    output mem_ready
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath selects and strobes, and traps
// on illegal encodings or a stalled memory handshake.
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mc_ctrl_fsm_if.master         mem,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  br_taken,
  output logic [2:0]            state,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic [2:0]            imm_sel,
  output logic                  alu_a_sel,
  output logic                  alu_b_sel,
  output logic [1:0]            alu_op,
  output logic                  reg_we,
  output logic [1:0]            wb_sel,
  output logic                  illegal,
  output logic                  bus_err
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_n;
  logic [CNT_W-1:0] wait_cnt;
  logic             set_ill, set_berr;

  // Immediate format for imm_gen: 0=I, 1=S, 2=B, 3=U, 4=J.
  function automatic logic [2:0] imm_fmt(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: imm_fmt = 3'd0;
      OP_STORE:                 imm_fmt = 3'd1;
      OP_BRANCH:                imm_fmt = 3'd2;
      OP_LUI, OP_AUIPC:         imm_fmt = 3'd3;
      OP_JAL:                   imm_fmt = 3'd4;
      default:                  imm_fmt = 3'd0;
    endcase
  endfunction

  // Reserved opcodes and reserved funct3 values within legal opcodes.
  function automatic logic bad_enc(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LOAD:   bad_enc = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OP_STORE:  bad_enc = f3[2] || (f3 == 3'b011);
      OP_BRANCH: bad_enc = (f3 == 3'b010) || (f3 == 3'b011);
      OP_JALR:   bad_enc = (f3 != 3'b000);
      OP_IMM, OP_REG, OP_JAL, OP_LUI, OP_AUIPC: bad_enc = 1'b0;
      default:   bad_enc = 1'b1;
    endcase
  endfunction

  // State register, memory wait counter and sticky trap flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_n != state_q)
        wait_cnt <= '0;
      else if ((state_q == FETCH || state_q == MEM) && !mem.mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (set_ill)  illegal <= 1'b1;
      if (set_berr) bus_err <= 1'b1;
    end
  end

  // Next-state and datapath control decode.
  // NOTE: every output gets a default before the case so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n     = state_q;
    set_ill     = 1'b0;
    set_berr    = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.mem_sel = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    imm_sel     = 3'd0;
    alu_a_sel   = 1'b0;
    alu_b_sel   = 1'b0;
    alu_op      = 2'd0;
    reg_we      = 1'b0;
    wb_sel      = 2'd0;

    case (state_q)
      BOOT: state_n = FETCH;

      FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_n = DECODE;
        end else if (wait_cnt == TIMEOUT) begin
          set_berr = 1'b1;
          state_n  = TRAP;
        end
      end

      DECODE: begin
        imm_sel = imm_fmt(opcode);
        if (bad_enc(opcode, funct3)) begin
          set_ill = 1'b1;
          state_n = TRAP;
        end else begin
          state_n = EXEC;
        end
      end

      EXEC: begin
        imm_sel = imm_fmt(opcode);
        state_n = WB;
        case (opcode)
          OP_REG:   alu_op = 2'd1;
          OP_IMM:   begin alu_b_sel = 1'b1; alu_op = 2'd1; end
          OP_LUI:   begin alu_b_sel = 1'b1; alu_op = 2'd3; end
          OP_AUIPC: begin alu_a_sel = 1'b1; alu_b_sel = 1'b1; end
          OP_LOAD, OP_STORE: begin
            alu_b_sel = 1'b1;
            state_n   = MEM;
          end
          OP_BRANCH: begin
            alu_op  = 2'd2;
            pc_we   = br_taken;
            pc_sel  = 2'd1;
            state_n = FETCH;
          end
          OP_JAL: begin
            pc_we  = 1'b1;
            pc_sel = 2'd1;
          end
          OP_JALR: begin
            alu_b_sel = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = 2'd2;
          end
          default: begin
            set_ill = 1'b1;
            state_n = TRAP;
          end
        endcase
      end

      MEM: begin
        imm_sel     = imm_fmt(opcode);
        mem.mem_req = 1'b1;
        mem.mem_sel = 1'b1;
        mem.mem_we  = (opcode == OP_STORE);
        if (mem.mem_ready) begin
          state_n = (opcode == OP_STORE) ? FETCH : WB;
        end else if (wait_cnt == TIMEOUT) begin
          set_berr = 1'b1;
          state_n  = TRAP;
        end
      end

      WB: begin
        imm_sel = imm_fmt(opcode);
        reg_we  = 1'b1;
        if (opcode == OP_LOAD)                          wb_sel = 2'd1;
        else if (opcode == OP_JAL || opcode == OP_JALR) wb_sel = 2'd2;
        state_n = FETCH;
      end

      TRAP: state_n = TRAP;

      default: begin
        set_ill = 1'b1;
        state_n = TRAP;
      end
    endcase
  end

  assign state = state_q;

endmodule
